// File: rtl/seg_scan_display.sv
// Six-digit multiplexed 7-segment scanner: latches a coherent BCD frame, then scans one digit per dwell.
// Optional build macro LEAD_ZERO_BLANK_EN darkens leading zero hour digits.
`timescale 1ns/1ps
module seg_scan_display #(
  parameter int DWELL_CYCLES = 50000,
  parameter bit SEG_POL      = 1'b1
) (
  input  logic       Clk,
  input  logic       rst_n,
  input  logic [3:0] hr_h,
  input  logic [3:0] hr_l,
  input  logic [3:0] min_h,
  input  logic [3:0] min_l,
  input  logic [3:0] sec_h,
  input  logic [3:0] sec_l,
  input  logic       blank,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [5:0] dig_sel,
  output logic       frame_done
);

  localparam int             CW      = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0]  TC      = CW'(DWELL_CYCLES - 1);
  localparam logic [6:0]     SEG_OFF = SEG_POL ? 7'h7F : 7'h00;
  localparam logic           DP_OFF  = SEG_POL;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [5:0][3:0] r_shadow;
  logic            r_load_first;

  logic       w_tc;
  logic       w_wrap;
  logic       w_load;
  logic       w_dark;
  logic       w_off;
  logic [3:0] w_digit;

  assign w_tc   = (r_cnt == TC);
  assign w_wrap = w_tc && (r_idx == 3'd5);
  assign w_load = r_load_first | w_wrap;

`ifdef LEAD_ZERO_BLANK_EN
  assign w_dark = ((r_idx == 3'd5) && (r_shadow[5] == 4'd0)) ||
                  ((r_idx == 3'd4) && (r_shadow[5] == 4'd0) && (r_shadow[4] == 4'd0));
`else
  assign w_dark = 1'b0;
`endif

  // The load_first cycle is kept dark so the first visible digit comes from the fresh load.
  assign w_off = blank | r_load_first | w_dark;

  always_comb begin
    w_digit = r_shadow[0];
    case (r_idx)
      3'd1:    w_digit = r_shadow[1];
      3'd2:    w_digit = r_shadow[2];
      3'd3:    w_digit = r_shadow[3];
      3'd4:    w_digit = r_shadow[4];
      3'd5:    w_digit = r_shadow[5];
      default: w_digit = r_shadow[0];
    endcase
  end

  // Scan control: dwell counter, slot index, frame pulse
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= 3'd0;
      r_load_first <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      r_load_first <= 1'b0;
      frame_done   <= w_wrap;
      if (w_tc) begin
        r_cnt <= '0;
        r_idx <= w_wrap ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Frame shadow: index 0 = sec_l ... index 5 = hr_h
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (w_load) begin
      r_shadow <= {hr_h, hr_l, min_h, min_l, sec_h, sec_l};
    end
  end

  // Output stage: one cycle behind idx/shadow
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_sel <= 6'b111111;
      seg_out <= SEG_OFF;
      dp_out  <= DP_OFF;
    end else if (w_off) begin
      dig_sel <= 6'b111111;
      seg_out <= SEG_OFF;
      dp_out  <= DP_OFF;
    end else begin
      dig_sel <= ~(6'b000001 << r_idx);
      seg_out <= seg_encode(w_digit) ^ {7{SEG_POL}};
      dp_out  <= ((r_idx == 3'd2) || (r_idx == 3'd4)) ^ SEG_POL;
    end
  end

endmodule
